// File: rtl/tour_pkg.sv
// tour_pkg: shared definitions for the tour command executor.
//   - opcode and heading byte constants of the 16-bit move command
//   - FSM state encoding
//   - board size and command-field legality helpers
package tour_pkg;

  localparam logic [3:0] OP_CAL     = 4'h0;
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  localparam logic [7:0] HDG_N = 8'h00;  // yy + 1
  localparam logic [7:0] HDG_W = 8'h3F;  // xx - 1
  localparam logic [7:0] HDG_S = 8'h7F;  // yy - 1
  localparam logic [7:0] HDG_E = 8'hBF;  // xx + 1

  localparam int BOARD_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_CAL,
    ST_STEP,
    ST_FANFARE,
    ST_RESP
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_CAL) || (op == OP_MOVE) || (op == OP_MOVE_FF);
  endfunction

  function automatic logic hdg_legal(input logic [7:0] hdg);
    return (hdg == HDG_N) || (hdg == HDG_W) || (hdg == HDG_S) || (hdg == HDG_E);
  endfunction

endpackage

// File: rtl/tour_cmd_exec_board_step.sv
// board_step: combinational one-square move on the 5x5 board.
//   hdg        in  8  heading byte (N/W/S/E constants from tour_pkg)
//   xx, yy     in  3  current square
//   nxt_x/y    out 3  square one step along hdg (only meaningful when on board)
//   off_board  out 1  the step would leave columns/rows 0..BOARD_MAX
module board_step
  import tour_pkg::*;
(
  input  logic [7:0] hdg,
  input  logic [2:0] xx,
  input  logic [2:0] yy,
  output logic [2:0] nxt_x,
  output logic [2:0] nxt_y,
  output logic       off_board
);

  localparam logic signed [3:0] LIM = 4'(BOARD_MAX);

  // 4-bit signed candidates so that 0 - 1 shows up as -1 instead of 7.
  logic signed [3:0] cand_x;
  logic signed [3:0] cand_y;

  always_comb begin
    cand_x = signed'({1'b0, xx});
    cand_y = signed'({1'b0, yy});
    case (hdg)
      HDG_N:   cand_y = cand_y + 4'sd1;
      HDG_S:   cand_y = cand_y - 4'sd1;
      HDG_E:   cand_x = cand_x + 4'sd1;
      HDG_W:   cand_x = cand_x - 4'sd1;
      default: ;
    endcase
    off_board = (cand_x < 4'sd0) || (cand_x > LIM) ||
                (cand_y < 4'sd0) || (cand_y > LIM);
    nxt_x = cand_x[2:0];
    nxt_y = cand_y[2:0];
  end

endmodule

// File: rtl/tour_cmd_exec.sv
// tour_cmd_exec: consumer side of the tour command interface.
// Accepts a 16-bit command on cmd/cmd_rdy, acknowledges with a one-cycle
// clr_cmd_rdy, walks the knight one square per SQ_CYCLES, optionally plays a
// fanfare, and reports completion with a one-cycle send_resp.
//   clk, rst       clock / asynchronous active-high reset
//   cmd, cmd_rdy   command word and its valid (held until clr_cmd_rdy)
//   init_pos       load init_x/init_y and clear err (IDLE only)
//   clr_cmd_rdy    command acknowledge
//   send_resp      completion pulse (normal or error)
//   xx, yy         knight position
//   fanfare        high during the fanfare interval
//   busy           high whenever not IDLE
//   err            sticky error flag
//   cmd_cnt        completed-command counter (wraps)
module tour_cmd_exec
  import tour_pkg::*;
#(
  parameter int SQ_CYCLES  = 16,
  parameter int FF_CYCLES  = 32,
  parameter int CAL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  input  logic        init_pos,
  input  logic [2:0]  init_x,
  input  logic [2:0]  init_y,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [2:0]  xx,
  output logic [2:0]  yy,
  output logic        fanfare,
  output logic        busy,
  output logic        err,
  output logic [5:0]  cmd_cnt
);

  localparam int MAX_CYC = (SQ_CYCLES > FF_CYCLES) ?
                           ((SQ_CYCLES > CAL_CYCLES) ? SQ_CYCLES : CAL_CYCLES) :
                           ((FF_CYCLES > CAL_CYCLES) ? FF_CYCLES : CAL_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         sq_left;
  logic [3:0]         op_q;
  logic [7:0]         hdg_q;
  logic [2:0]         nxt_x;
  logic [2:0]         nxt_y;
  logic               off_board;
  logic               is_move;

  assign is_move = (op_q == OP_MOVE) || (op_q == OP_MOVE_FF);

  board_step u_board_step (
    .hdg       (hdg_q),
    .xx        (xx),
    .yy        (yy),
    .nxt_x     (nxt_x),
    .nxt_y     (nxt_y),
    .off_board (off_board)
  );

  // Command capture: data only, taken on the edge that moves IDLE -> ACK.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && cmd_rdy) begin
      op_q  <= cmd[15:12];
      hdg_q <= cmd[11:4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sq_left     <= '0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      xx          <= '0;
      yy          <= '0;
      fanfare     <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      cmd_cnt     <= '0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A pending command takes priority over init_pos.
          if (cmd_rdy) begin
            state       <= ST_ACK;
            clr_cmd_rdy <= 1'b1;
            busy        <= 1'b1;
            sq_left     <= cmd[3:0];
          end else if (init_pos) begin
            xx  <= init_x;
            yy  <= init_y;
            err <= 1'b0;
          end
        end
        ST_ACK: begin
          if (!op_legal(op_q) || (is_move && (!hdg_legal(hdg_q) || sq_left == 4'd0))) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end else if (op_q == OP_CAL) begin
            state <= ST_CAL;
            cnt   <= CNT_W'(CAL_CYCLES - 1);
          end else begin
            state <= ST_STEP;
            cnt   <= CNT_W'(SQ_CYCLES - 1);
          end
        end
        ST_CAL: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_STEP: begin
          // Position only moves on the last cycle of a square.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (off_board) begin
            err   <= 1'b1;
            state <= ST_RESP;
          end else begin
            xx <= nxt_x;
            yy <= nxt_y;
            if (sq_left != 4'd1) begin
              sq_left <= sq_left - 4'd1;
              cnt     <= CNT_W'(SQ_CYCLES - 1);
            end else if (op_q == OP_MOVE_FF) begin
              state   <= ST_FANFARE;
              fanfare <= 1'b1;
              cnt     <= CNT_W'(FF_CYCLES - 1);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_FANFARE: begin
          if (cnt == '0) begin
            fanfare <= 1'b0;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          send_resp <= 1'b1;
          cmd_cnt   <= cmd_cnt + 6'd1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tour_cmd_exec.md
# tour_cmd_exec

Synthesizable command executor sitting on the consumer side of the tour command interface: it accepts 16-bit move commands over the cmd/cmd_rdy handshake, acknowledges with clr_cmd_rdy, walks the knight's board position one square at a time, and signals completion with send_resp. It stands in for the motion path during tour bring-up and FPGA debug, and tracks x/y position plus error status so the command sequencer can be checked end-to-end.

## Interface
- SQ_CYCLES, default 16: clock cycles spent per square moved (≥2).
- FF_CYCLES, default 32: extra cycles of fanfare after a fanfare move (≥1).
- CAL_CYCLES, default 8: cycles a calibrate command takes (≥1).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  16  command: [15:12] opcode, [11:4] heading byte, [3:0] square count.
- cmd_rdy  in  1  cmd valid; held by the producer until clr_cmd_rdy.
- init_pos  in  1  loads init_x/init_y into position; honoured only in IDLE.
- init_x, init_y  in  3 each  start square, 0–4.
- clr_cmd_rdy  out  1  one-cycle acknowledge; cmd captured in the same edge.
- send_resp  out  1  one-cycle pulse when the command finishes (normal or error).
- xx, yy  out  3 each  current knight position.
- fanfare  out  1  high during the fanfare interval.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error; cleared only by rst or init_pos.
- cmd_cnt  out  6  commands completed, wraps 63→0.

## Operation
- Opcodes: 4'h0 CAL, 4'h2 MOVE, 4'h3 MOVE_FF; all others are illegal.
- Headings: 8'h00 north (yy+1), 8'h3F west (xx−1), 8'h7F south (yy−1), 8'hBF east (xx+1); all others are illegal.
- States: IDLE, ACK, CAL, STEP, FANFARE, RESP.
- IDLE: when cmd_rdy=1, go to ACK. When init_pos=1 and cmd_rdy=0, load position and clear err. When both are high, the command wins and init_pos is ignored.
- ACK: assert clr_cmd_rdy and latch cmd into op/hdg/sq registers. Then:
  - illegal opcode, illegal heading on a move, or sq=0 on a move: set err, go to RESP;
  - CAL: go to CAL;
  - MOVE or MOVE_FF: go to STEP.
- CAL: count CAL_CYCLES, then go to RESP. Position is unchanged.
- STEP: count SQ_CYCLES per square. At the end of each square:
  - if the target square is outside 0–4: leave position unchanged, set err, go to RESP;
  - otherwise update xx/yy and decrement the remaining count.
  - When the remaining count reaches 0, go to FANFARE for MOVE_FF, or to RESP for MOVE.
- FANFARE: fanfare=1 for FF_CYCLES cycles, then go to RESP.
- RESP: assert send_resp for one cycle, increment cmd_cnt (errors included), go to IDLE.
- Position arithmetic is 3-bit unsigned. The bounds check runs on a 4-bit signed candidate value so that 0−1 is never wrapped to 7.

## Timing
- Reset values: all outputs 0; state IDLE; err 0; cmd_cnt 0; xx=yy=0.
- cmd_rdy sampled high at edge N → clr_cmd_rdy high for cycle N+1 only. cmd is not sampled again until the next return to IDLE.
- cmd_rdy still high on returning to IDLE (producer has not yet dropped it after clr): it is treated as a new command. Producers must drop cmd_rdy within one cycle of clr_cmd_rdy.
- MOVE of n squares: send_resp asserts 1 + n·SQ_CYCLES + 1 cycles after the ACK edge.
  - MOVE_FF adds FF_CYCLES.
  - CAL: send_resp asserts 1 + CAL_CYCLES + 1 cycles after the ACK edge.
- Position updates on the final cycle of each square's count, never mid-square.
- Error found in ACK: send_resp follows exactly one cycle after clr_cmd_rdy.
- rst asserted mid-command: immediate return to reset values; no send_resp is emitted.

## Structure
- Package tour_pkg holds:
  - the opcode localparams (OP_CAL, OP_MOVE, OP_MOVE_FF);
  - the heading byte constants (HDG_N/W/S/E);
  - the state enum typedef;
  - BOARD_MAX=4.
- The cycle counter is shared by CAL, STEP and FANFARE, reloaded on each state entry; it is sized to the largest parameter.
- One sub-module, board_step: combinational; takes hdg, xx, yy and produces nxt_x, nxt_y, off_board. Unit-testable on its own.

## Test plan
- Reset, init_pos with (2,2), cmd 16'h2002 (north 2) → clr_cmd_rdy one cycle after cmd_rdy; send_resp at ACK+34; yy=4, xx=2, err=0, cmd_cnt=1.
- From (2,4), cmd 16'h3BF1 (east 1, fanfare) → xx=3 at ACK+17; fanfare high 32 cycles; send_resp at ACK+50.
- From (0,0), cmd 16'h23F1 (west 1) → err=1 after 16 cycles; position stays (0,0); send_resp pulses once; cmd_cnt increments.
- cmd 16'h7000 (illegal opcode) and cmd 16'h2122 (bad heading) → err=1; send_resp exactly one cycle after clr_cmd_rdy; position unchanged.
- cmd 16'h0000 (CAL) → send_resp at ACK+10; position unchanged. Then init_pos → err cleared.
- rst pulsed mid-STEP of 16'h2003 → all outputs 0 within the same cycle; no send_resp; next cmd accepted normally.
